pcpi_issue_ctrl: RTL and testbench
==================================

Name: pcpi_issue_ctrl

Overview:
- Initiator (core) side of the PCPI coprocessor interface.
- Takes one instruction plus operands from the core's execute stage over a valid/ready request port.
- Drives pcpi_valid/insn/rs1/rs2 to any attached PCPI responders (e.g. the div/rem unit), tracks pcpi_wait/pcpi_ready, and applies a no-claim timeout.
- Returns result, write-enable, or an illegal-instruction flag over a valid/ready response port.

Parameters:
- TIMEOUT, 16: cycles pcpi_valid may stay high with neither pcpi_wait nor pcpi_ready sampled before the instruction is declared illegal. Legal range 4..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core offers an instruction
- req_ready  out  1  block can accept; high only in IDLE
- req_insn  in  32  instruction word
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- pcpi_valid  out  1  instruction presented to responders
- pcpi_insn  out  32  registered copy of req_insn
- pcpi_rs1  out  32  registered copy of req_rs1
- pcpi_rs2  out  32  registered copy of req_rs2
- pcpi_wr  in  1  responder writes rd, sampled with pcpi_ready
- pcpi_rd  in  32  responder result
- pcpi_wait  in  1  responder has claimed the instruction
- pcpi_ready  in  1  responder result valid, one-cycle pulse
- rsp_valid  out  1  response available
- rsp_ready  in  1  core consumes response
- rsp_wr  out  1  captured pcpi_wr; 0 when illegal
- rsp_rd  out  32  captured pcpi_rd; 0 when illegal
- rsp_illegal  out  1  no responder claimed the instruction within TIMEOUT

Behaviour:
- Reset: all outputs 0 (pcpi_insn/rs1/rs2 = 0, rsp_rd = 0). State IDLE, timeout counter 0, claimed flag 0.
  - Reset during any state aborts the operation: pcpi_valid = 0 after that edge; any pending response is dropped.
- States IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Registered outputs are derived from state.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch insn/rs1/rs2, go ISSUE; pcpi_valid = 1 from the next cycle. Counter = 1.
- ISSUE (pcpi_valid = 1):
  - pcpi_ready sampled: capture pcpi_wr/pcpi_rd, go RESP.
  - Otherwise, pcpi_wait sampled: go WAIT.
  - Otherwise, counter == TIMEOUT: go RESP with illegal = 1, wr = 0, rd = 0.
  - Otherwise: counter + 1.
  - pcpi_valid is therefore high exactly TIMEOUT cycles for an unclaimed instruction.
- WAIT (pcpi_valid = 1):
  - No timeout applies.
  - pcpi_wait may drop before pcpi_ready; the block stays in WAIT.
  - pcpi_ready sampled: capture, go RESP.
- Precedence on one edge: pcpi_ready beats pcpi_wait, which beats timeout. A ready on the same edge the counter reaches TIMEOUT is a normal completion, not illegal.
- Zero-latency responder (pcpi_ready in the first ISSUE cycle) is legal.
- pcpi_valid drops the cycle after pcpi_ready is sampled. Responders must tolerate valid high in the same cycle as their ready pulse.
- RESP:
  - pcpi_valid = 0, rsp_valid = 1.
  - rsp_wr/rsp_rd/rsp_illegal held stable until rsp_ready; then go IDLE and rsp_valid = 0 on the next cycle.
  - Guarantees at least 2 cycles of pcpi_valid low between instructions, so a responder's registered decode clears.
- pcpi_ready/pcpi_wait in IDLE or RESP are ignored.
- pcpi_insn/rs1/rs2 stay stable from ISSUE entry until the next request is latched.
- Throughput: at most one instruction in flight.

Optional Feature:
- PCPI_CYCLE_COUNT_EN
- Defined:
  - Adds output rsp_cycles [15:0]: number of cycles pcpi_valid was high for the returned instruction.
  - Saturates at 0xFFFF; held with the response; 0 on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DIVU 0x0220D1B3, rs1 = 100, rs2 = 7, div/rem responder attached -> single rsp: rsp_rd = 14, rsp_wr = 1, rsp_illegal = 0; pcpi_valid low 1 cycle after pcpi_ready.
- REM 0x0220E1B3, rs1 = 0xFFFFFFF9 (-7), rs2 = 2 -> rsp_rd = 0xFFFFFFFF, rsp_wr = 1.
- DIV 0x0220C1B3, rs2 = 0 -> rsp_rd = 0xFFFFFFFF, rsp_wr = 1; no timeout even though ready follows wait quickly.
- ADD 0x002081B3, no responder claims -> pcpi_valid high exactly 16 cycles, then rsp_illegal = 1, rsp_wr = 0, rsp_rd = 0. With PCPI_CYCLE_COUNT_EN, rsp_cycles = 16.
- Stalled consumer: rsp_ready low 5 cycles after completing DIVU 100/7 -> rsp_valid/rsp_rd = 14 stable all 5 cycles; req_ready = 0 throughout; new req_valid ignored until after handshake.
- Assert reset for 1 cycle while in WAIT mid-divide -> pcpi_valid = 0 and rsp_valid = 0 next cycle, req_ready = 1. A following DIVU 100/7 returns 14 correctly.

Source files
------------

// File: rtl/pcpi_issue_ctrl.sv
// Core-side PCPI issue controller: launches one instruction to the responders and returns its
// result, or flags it illegal when no responder claims it. Optional macro: PCPI_CYCLE_COUNT_EN.
module pcpi_issue_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,

    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
`ifdef PCPI_CYCLE_COUNT_EN
    output logic [15:0] rsp_cycles,
`endif
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        illegal_q, illegal_d;
    logic        active;

    assign active = (state_q == StIssue) || (state_q == StWait);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        insn_d    = insn_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rsp_wr_d  = rsp_wr_q;
        rsp_rd_d  = rsp_rd_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    insn_d  = req_insn;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    cnt_d   = 8'd1;
                    state_d = StIssue;
                end
            end
            // Ready beats wait beats timeout, so a ready on the timeout edge completes normally.
            StIssue: begin
                if (pcpi_ready) begin
                    rsp_wr_d  = pcpi_wr;
                    rsp_rd_d  = pcpi_rd;
                    illegal_d = 1'b0;
                    state_d   = StResp;
                end else if (pcpi_wait) begin
                    state_d = StWait;
                end else if (cnt_q == TimeoutCnt) begin
                    rsp_wr_d  = 1'b0;
                    rsp_rd_d  = 32'h0;
                    illegal_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // Once claimed the responder may take arbitrarily long; wait may also drop early.
            StWait: begin
                if (pcpi_ready) begin
                    rsp_wr_d  = pcpi_wr;
                    rsp_rd_d  = pcpi_rd;
                    illegal_d = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            insn_q    <= 32'h0;
            rs1_q     <= 32'h0;
            rs2_q     <= 32'h0;
            rsp_wr_q  <= 1'b0;
            rsp_rd_q  <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            insn_q    <= insn_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rsp_wr_q  <= rsp_wr_d;
            rsp_rd_q  <= rsp_rd_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef PCPI_CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == StIdle && req_valid) begin
            cyc_d = 16'd0;
        end else if (active && cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign rsp_cycles = cyc_q;
`endif

    assign req_ready   = (state_q == StIdle);
    assign pcpi_valid  = active;
    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_wr      = rsp_wr_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Directed bench for pcpi_issue_ctrl with a configurable div/rem responder model.
module tb_pcpi_issue_ctrl;

    localparam logic [31:0] Divu = 32'h0220D1B3;
    localparam logic [31:0] Rem  = 32'h0220E1B3;
    localparam logic [31:0] Div  = 32'h0220C1B3;
    localparam logic [31:0] Add  = 32'h002081B3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_illegal;
    logic [31:0] rsp_rd;
`ifdef PCPI_CYCLE_COUNT_EN
    logic [15:0] rsp_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcpi_issue_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wr     (rsp_wr),
        .rsp_rd     (rsp_rd),
`ifdef PCPI_CYCLE_COUNT_EN
        .rsp_cycles (rsp_cycles),
`endif
        .rsp_illegal(rsp_illegal)
    );

    // Responder model: claims with wait for cycle indices [r_wait_from, r_wait_until) and
    // pulses ready at index r_rdy_at, where index 0 is the first cycle pcpi_valid is seen.
    logic        r_claim;
    int unsigned r_wait_from, r_wait_until, r_rdy_at;
    int unsigned vcnt_q;
    logic        done_q;
    logic        is_div;

    function automatic logic [31:0] mdiv(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        unique case (f)
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    assign is_div = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                    pcpi_insn[14];
    assign pcpi_ready = is_div && pcpi_valid && !done_q && (vcnt_q == r_rdy_at);
    assign pcpi_wait  = r_claim && is_div && pcpi_valid && !done_q && !pcpi_ready &&
                        (vcnt_q >= r_wait_from) && (vcnt_q < r_wait_until);
    assign pcpi_wr    = pcpi_ready;
    assign pcpi_rd    = pcpi_ready ? mdiv(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2) : 32'h0;

    always @(posedge clk) begin
        if (reset || !pcpi_valid) begin
            vcnt_q <= 0;
            done_q <= 1'b0;
        end else if (!done_q) begin
            if (pcpi_ready) done_q <= 1'b1;
            vcnt_q <= vcnt_q + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic responder(input logic claim, input int unsigned wf, input int unsigned wu,
                             input int unsigned rdy);
        r_claim      = claim;
        r_wait_from  = wf;
        r_wait_until = wu;
        r_rdy_at     = rdy;
    endtask

    // Issue one request and wait for rsp_valid, counting cycles with pcpi_valid high.
    task automatic issue(input string tag, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, output int vc);
        int n;
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = a;
        req_rs2   = b;
        step();
        req_valid = 1'b0;
        vc = 0;
        n  = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (pcpi_valid === 1'b1) vc++;
            step();
            n++;
        end
        chk({tag, ".bound"}, 32'(n < 300), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input int vc, input int exp_vc,
                              input logic [31:0] exp_rd, input logic exp_wr,
                              input logic exp_ill);
        chk({tag, ".vcycles"}, 32'(vc), 32'(exp_vc));
        chk({tag, ".rd"}, rsp_rd, exp_rd);
        chk({tag, ".wr"}, 32'(rsp_wr), 32'(exp_wr));
        chk({tag, ".illegal"}, 32'(rsp_illegal), 32'(exp_ill));
        chk({tag, ".pvalid_low"}, 32'(pcpi_valid), 32'd0);
`ifdef PCPI_CYCLE_COUNT_EN
        chk({tag, ".cycles"}, 32'(rsp_cycles), 32'(exp_vc));
`endif
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int vc;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_insn  = 32'h0;
        req_rs1   = 32'h0;
        req_rs2   = 32'h0;
        rsp_ready = 1'b0;
        responder(1'b1, 0, 1000, 5);
        step();
        step();
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.pcpi_insn", pcpi_insn, 32'h0);
        chk("reset.rsp_rd", rsp_rd, 32'h0);
        chk("reset.rsp_illegal", 32'(rsp_illegal), 32'd0);
        reset = 1'b0;
        step();

        // DIVU 100/7, claimed, ready at index 5
        issue("divu", Divu, 32'd100, 32'd7, vc);
        expect_rsp("divu", vc, 6, 32'd14, 1'b1, 1'b0);
        chk("divu.req_ready_busy", 32'(req_ready), 32'd0);
        chk("divu.insn_held", pcpi_insn, Divu);
        chk("divu.rs2_held", pcpi_rs2, 32'd7);
        handshake("divu");

        // REM -7 % 2
        responder(1'b1, 0, 1000, 3);
        issue("rem", Rem, 32'hFFFF_FFF9, 32'd2, vc);
        expect_rsp("rem", vc, 4, 32'hFFFF_FFFF, 1'b1, 1'b0);
        handshake("rem");

        // DIV by zero, quick ready after wait
        responder(1'b1, 0, 1000, 1);
        issue("div0", Div, 32'd55, 32'd0, vc);
        expect_rsp("div0", vc, 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        handshake("div0");

        // Wait drops early, ready long after TIMEOUT: still no timeout once claimed
        responder(1'b1, 0, 2, 20);
        issue("waitdrop", Divu, 32'd100, 32'd7, vc);
        expect_rsp("waitdrop", vc, 21, 32'd14, 1'b1, 1'b0);
        handshake("waitdrop");

        // Unclaimed ADD times out after exactly 16 cycles of pcpi_valid
        issue("add", Add, 32'd1, 32'd2, vc);
        expect_rsp("add", vc, 16, 32'h0, 1'b0, 1'b1);
        handshake("add");

        // Zero-latency responder
        responder(1'b0, 0, 0, 0);
        issue("zerolat", Divu, 32'd100, 32'd7, vc);
        expect_rsp("zerolat", vc, 1, 32'd14, 1'b1, 1'b0);
        handshake("zerolat");

        // Unclaimed ready on the very timeout edge completes normally
        responder(1'b0, 0, 0, 15);
        issue("edge_ok", Divu, 32'd100, 32'd7, vc);
        expect_rsp("edge_ok", vc, 16, 32'd14, 1'b1, 1'b0);
        handshake("edge_ok");

        // One cycle later is too late
        responder(1'b0, 0, 0, 16);
        issue("edge_late", Divu, 32'd100, 32'd7, vc);
        expect_rsp("edge_late", vc, 16, 32'h0, 1'b0, 1'b1);
        handshake("edge_late");

        // Stalled consumer with a competing request pending
        responder(1'b1, 0, 1000, 5);
        issue("stall", Divu, 32'd100, 32'd7, vc);
        expect_rsp("stall", vc, 6, 32'd14, 1'b1, 1'b0);
        req_valid = 1'b1;
        req_insn  = Add;
        req_rs1   = 32'd9;
        req_rs2   = 32'd9;
        for (int i = 0; i < 5; i++) begin
            chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall.rsp_rd", rsp_rd, 32'd14);
            chk("stall.req_ready", 32'(req_ready), 32'd0);
            chk("stall.pcpi_valid", 32'(pcpi_valid), 32'd0);
            step();
        end
        req_valid = 1'b0;
        handshake("stall");
        chk("stall.insn_kept", pcpi_insn, Divu);
        chk("stall.no_issue", 32'(pcpi_valid), 32'd0);

        // Reset mid-divide while in WAIT
        responder(1'b1, 0, 1000, 10);
        req_valid = 1'b1;
        req_insn  = Divu;
        req_rs1   = 32'd100;
        req_rs2   = 32'd7;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("abort.in_wait", 32'(pcpi_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort.pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort.req_ready", 32'(req_ready), 32'd1);
        step();
        responder(1'b1, 0, 1000, 5);
        issue("after", Divu, 32'd100, 32'd7, vc);
        expect_rsp("after", vc, 6, 32'd14, 1'b1, 1'b0);
        handshake("after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
